// File: rtl/track_loader_pkg.sv
// Shared constants, FSM state encoding and track clamp helper for the track loader.
// Pure declarations: no timing, no flow control.
package track_loader_pkg;

  localparam int BLOCKS_PER_TRACK = 13;
  localparam int MAX_TRACK        = 34;
  localparam int SD_BLOCK_BYTES   = 512;
  localparam int TRACK_BYTES      = BLOCKS_PER_TRACK * SD_BLOCK_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR_REQ,
    ST_WR_XFER,
    ST_RD_REQ,
    ST_RD_XFER
  } state_t;

  function automatic logic [5:0] clamp_track(input logic [5:0] t, input int max_t);
    return (int'(t) > max_t) ? 6'(max_t) : t;
  endfunction

endpackage

// File: rtl/track_ram.sv
// True dual-port byte RAM holding one track; both read ports registered, 1-cycle latency.
// No backpressure: every port accepts an access each cycle; out-of-range writes are dropped.
module track_ram
  import track_loader_pkg::*;
#(
  parameter int DEPTH = TRACK_BYTES
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic [12:0] addr_a,
  input  logic [7:0]  di_a,
  input  logic        we_a,
  output logic [7:0]  do_a,
  input  logic [12:0] addr_b,
  input  logic [7:0]  di_b,
  input  logic        we_b,
  output logic [7:0]  do_b
);

  logic [7:0] mem [DEPTH];

  logic in_a;
  logic in_b;

  assign in_a = int'(addr_a) < DEPTH;
  assign in_b = int'(addr_b) < DEPTH;

  // Contents are never reset; only the output registers are.
  always_ff @(posedge CLK_14M) begin
    if (we_a && in_a) mem[addr_a] <= di_a;
    if (we_b && in_b) mem[addr_b] <= di_b;
    if (RESET) begin
      do_a <= '0;
      do_b <= '0;
    end else begin
      do_a <= in_a ? mem[addr_a] : 8'h00;
      do_b <= in_b ? mem[addr_b] : 8'h00;
    end
  end

endmodule

// File: rtl/track_loader.sv
// Caches one disk track in RAM, writing back a dirty track and loading the requested one block-by-block over the SD host handshake.
// Drive reads have 1-cycle latency; drive writes are dropped while TRACK_BUSY; each block waits for the host SD_ACK window.
module track_loader #(
  parameter int BLOCKS_PER_TRACK = track_loader_pkg::BLOCKS_PER_TRACK,
  parameter int MAX_TRACK        = track_loader_pkg::MAX_TRACK
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        IMG_MOUNTED,
  input  logic        IMG_READONLY,
  input  logic [5:0]  TRACK,
  input  logic [12:0] TRACK_ADDR,
  input  logic [7:0]  TRACK_DI,
  input  logic        TRACK_WE,
  output logic [7:0]  TRACK_DO,
  output logic        TRACK_BUSY,
  output logic        DISK_READY,
  output logic [31:0] SD_LBA,
  output logic        SD_RD,
  output logic        SD_WR,
  input  logic        SD_ACK,
  input  logic [8:0]  SD_BUFF_ADDR,
  input  logic [7:0]  SD_BUFF_DOUT,
  input  logic        SD_BUFF_WR,
  output logic [7:0]  SD_BUFF_DIN
);

  import track_loader_pkg::*;

  state_t      state, state_n;
  logic [3:0]  blk, blk_n;
  logic [5:0]  cur_track, cur_track_n;
  logic [5:0]  tgt, tgt_n;
  logic        valid, valid_n;
  logic        dirty, dirty_n;
  logic        ready_n;
  logic        ack_d;
  logic        rd_n, wr_n, busy_n;
  logic [31:0] lba_n;

  logic [5:0]  req_track;
  logic        ack_rise, ack_fall, last_blk;
  logic        we_a, we_b;
  logic [12:0] addr_b;

  assign req_track = clamp_track(TRACK, MAX_TRACK);
  assign ack_rise  = SD_ACK & ~ack_d;
  assign ack_fall  = ~SD_ACK & ack_d;
  assign last_blk  = (blk == 4'(BLOCKS_PER_TRACK - 1));

  // Writes are gated by RESET too, so the edge that samples reset cannot land a stray byte.
  assign we_a   = TRACK_WE & ~TRACK_BUSY & ~RESET;
  assign we_b   = SD_BUFF_WR & (state == ST_RD_XFER) & ~RESET;
  assign addr_b = {blk, SD_BUFF_ADDR};

  track_ram #(
    .DEPTH (BLOCKS_PER_TRACK * SD_BLOCK_BYTES)
  ) u_ram (
    .CLK_14M (CLK_14M),
    .RESET   (RESET),
    .addr_a  (TRACK_ADDR),
    .di_a    (TRACK_DI),
    .we_a    (we_a),
    .do_a    (TRACK_DO),
    .addr_b  (addr_b),
    .di_b    (SD_BUFF_DOUT),
    .we_b    (we_b),
    .do_b    (SD_BUFF_DIN)
  );

  always_comb begin
    state_n     = state;
    blk_n       = blk;
    cur_track_n = cur_track;
    tgt_n       = tgt;
    valid_n     = valid;
    dirty_n     = dirty;
    ready_n     = DISK_READY;

    if (we_a && !IMG_READONLY) dirty_n = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (DISK_READY && (!valid || req_track != cur_track)) begin
          state_n = ST_CHECK;
          tgt_n   = req_track;
        end
      end
      ST_CHECK: begin
        if (dirty && valid) begin
          state_n = ST_WR_REQ;
        end else begin
          blk_n   = '0;
          state_n = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (ack_rise) state_n = ST_WR_XFER;
      end
      ST_WR_XFER: begin
        if (ack_fall) begin
          if (last_blk) begin
            blk_n   = '0;
            dirty_n = 1'b0;
            state_n = ST_RD_REQ;
          end else begin
            blk_n   = blk + 4'd1;
            state_n = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        if (ack_rise) state_n = ST_RD_XFER;
      end
      ST_RD_XFER: begin
        if (ack_fall) begin
          if (last_blk) begin
            blk_n       = '0;
            cur_track_n = tgt;
            valid_n     = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            blk_n   = blk + 4'd1;
            state_n = ST_RD_REQ;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A new image discards everything, including a pending write-back of the old track.
    if (IMG_MOUNTED) begin
      state_n = ST_IDLE;
      blk_n   = '0;
      valid_n = 1'b0;
      dirty_n = 1'b0;
      ready_n = 1'b1;
    end

    rd_n = (state_n == ST_RD_REQ);
    wr_n = (state_n == ST_WR_REQ);

    lba_n = SD_LBA;
    if (state_n == ST_WR_REQ || state_n == ST_WR_XFER)
      lba_n = 32'(cur_track_n) * 32'(BLOCKS_PER_TRACK) + 32'(blk_n);
    else if (state_n == ST_RD_REQ || state_n == ST_RD_XFER)
      lba_n = 32'(tgt_n) * 32'(BLOCKS_PER_TRACK) + 32'(blk_n);

    busy_n = (state_n != ST_IDLE) || !valid_n || !ready_n || (req_track != cur_track_n);
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state      <= ST_IDLE;
      blk        <= '0;
      cur_track  <= '0;
      tgt        <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      DISK_READY <= 1'b0;
      SD_RD      <= 1'b0;
      SD_WR      <= 1'b0;
      SD_LBA     <= '0;
      TRACK_BUSY <= 1'b1;
      ack_d      <= 1'b0;
    end else begin
      state      <= state_n;
      blk        <= blk_n;
      cur_track  <= cur_track_n;
      tgt        <= tgt_n;
      valid      <= valid_n;
      dirty      <= dirty_n;
      DISK_READY <= ready_n;
      SD_RD      <= rd_n;
      SD_WR      <= wr_n;
      SD_LBA     <= lba_n;
      TRACK_BUSY <= busy_n;
      ack_d      <= SD_ACK;
    end
  end

endmodule

// File: tb/tb_track_loader.sv
// Directed bench for track_loader: host responder, request scoreboard and drive-side checks.
module tb_track_loader;

  logic        CLK_14M;
  logic        RESET;
  logic        IMG_MOUNTED;
  logic        IMG_READONLY;
  logic [5:0]  TRACK;
  logic [12:0] TRACK_ADDR;
  logic [7:0]  TRACK_DI;
  logic        TRACK_WE;
  logic [7:0]  TRACK_DO;
  logic        TRACK_BUSY;
  logic        DISK_READY;
  logic [31:0] SD_LBA;
  logic        SD_RD;
  logic        SD_WR;
  logic        SD_ACK;
  logic [8:0]  SD_BUFF_ADDR;
  logic [7:0]  SD_BUFF_DOUT;
  logic        SD_BUFF_WR;
  logic [7:0]  SD_BUFF_DIN;

  track_loader dut (
    .CLK_14M      (CLK_14M),
    .RESET        (RESET),
    .IMG_MOUNTED  (IMG_MOUNTED),
    .IMG_READONLY (IMG_READONLY),
    .TRACK        (TRACK),
    .TRACK_ADDR   (TRACK_ADDR),
    .TRACK_DI     (TRACK_DI),
    .TRACK_WE     (TRACK_WE),
    .TRACK_DO     (TRACK_DO),
    .TRACK_BUSY   (TRACK_BUSY),
    .DISK_READY   (DISK_READY),
    .SD_LBA       (SD_LBA),
    .SD_RD        (SD_RD),
    .SD_WR        (SD_WR),
    .SD_ACK       (SD_ACK),
    .SD_BUFF_ADDR (SD_BUFF_ADDR),
    .SD_BUFF_DOUT (SD_BUFF_DOUT),
    .SD_BUFF_WR   (SD_BUFF_WR),
    .SD_BUFF_DIN  (SD_BUFF_DIN)
  );

  initial begin
    CLK_14M = 1'b0;
    forever #5 CLK_14M = ~CLK_14M;
  end

  typedef struct {
    bit wr;
    int lba;
  } req_t;

  req_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_buf [6656];
  int         blocks_done = 0;
  int         wr_blocks = 0;
  logic [7:0] wb_b1_0 = 8'h00;
  int         abort_lba = -1;
  int         abort_idx = 0;
  bit         host_stalled = 0;
  bit         host_junk_done = 0;

  function automatic logic [7:0] data(input int lba, input int i);
    return 8'(lba * 29 + i * 3 + (i >> 7));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_reqs(input bit wr, input int first, input int count);
    req_t r;
    for (int k = 0; k < count; k++) begin
      r.wr  = wr;
      r.lba = first + k;
      exp_q.push_back(r);
    end
  endtask

  task automatic load_model(input int t);
    for (int b = 0; b < 13; b++)
      for (int i = 0; i < 512; i++)
        model_buf[b * 512 + i] = data(t * 13 + b, i);
  endtask

  // Host responder: answers each SD_RD/SD_WR with a 512-byte transfer window.
  initial begin
    int  lba;
    bit  is_wr;
    bit  aborted;
    int  bad;
    int  first_bad;
    SD_ACK       = 1'b0;
    SD_BUFF_ADDR = '0;
    SD_BUFF_DOUT = '0;
    SD_BUFF_WR   = 1'b0;
    forever begin
      @(negedge CLK_14M);
      if ((SD_RD || SD_WR) && !RESET) begin
        is_wr     = SD_WR;
        lba       = int'(SD_LBA);
        aborted   = 0;
        bad       = 0;
        first_bad = -1;
        @(negedge CLK_14M);
        @(negedge CLK_14M);
        SD_ACK = 1'b1;
        @(negedge CLK_14M);
        for (int i = 0; i < 512; i++) begin
          SD_BUFF_ADDR = 9'(i);
          if (!is_wr) begin
            SD_BUFF_DOUT = data(lba, i);
            SD_BUFF_WR   = 1'b1;
          end
          if (lba == abort_lba && i == abort_idx) begin
            host_stalled = 1;
            while (abort_lba == lba) @(negedge CLK_14M);
            SD_BUFF_WR = 1'b0;
            SD_ACK     = 1'b0;
            @(negedge CLK_14M);
            for (int j = 0; j < 9; j++) begin
              SD_BUFF_ADDR = (j < 8) ? 9'(j) : 9'd100;
              SD_BUFF_DOUT = 8'hEE;
              SD_BUFF_WR   = 1'b1;
              @(negedge CLK_14M);
            end
            SD_BUFF_WR     = 1'b0;
            host_junk_done = 1;
            aborted        = 1;
            break;
          end
          @(negedge CLK_14M);
          if (is_wr) begin
            if (SD_BUFF_DIN != model_buf[(lba % 13) * 512 + i]) begin
              bad++;
              if (first_bad < 0) first_bad = i;
            end
            if (lba % 13 == 1 && i == 0) wb_b1_0 = SD_BUFF_DIN;
          end
        end
        if (!aborted) begin
          SD_BUFF_WR = 1'b0;
          SD_ACK     = 1'b0;
          blocks_done++;
          if (is_wr) begin
            wr_blocks++;
            if (bad != 0) $display("FAIL wb_block lba=%0d first_bad_idx=%0d", lba, first_bad);
            check("wb_block_bad_bytes", bad, 0);
          end
        end
      end
    end
  end

  // Monitor: every new request is popped against the expected request queue.
  initial begin
    logic prev_rd;
    logic prev_wr;
    req_t e;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge CLK_14M);
      if (!RESET && ((SD_RD && !prev_rd) || (SD_WR && !prev_wr))) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req rd=%0d wr=%0d lba=%0d required=none", SD_RD, SD_WR, SD_LBA);
        end else begin
          e = exp_q.pop_front();
          check("req_is_write", int'(SD_WR), int'(e.wr));
          check("req_lba", int'(SD_LBA), e.lba);
        end
      end
      prev_rd = SD_RD;
      prev_wr = SD_WR;
    end
  end

  task automatic wait_not_busy(input string name);
    bit ok;
    ok = 0;
    repeat (3) @(negedge CLK_14M);
    for (int c = 0; c < 30000; c++) begin
      @(negedge CLK_14M);
      if (!TRACK_BUSY) begin
        ok = 1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  task automatic read_do(input logic [12:0] a, output logic [7:0] v);
    @(negedge CLK_14M);
    TRACK_ADDR = a;
    @(negedge CLK_14M);
    v = TRACK_DO;
  endtask

  task automatic drive_write(input logic [12:0] a, input logic [7:0] d);
    @(negedge CLK_14M);
    TRACK_ADDR = a;
    TRACK_DI   = d;
    TRACK_WE   = 1'b1;
    @(negedge CLK_14M);
    TRACK_WE   = 1'b0;
  endtask

  task automatic pulse_mount(input logic [5:0] t);
    @(negedge CLK_14M);
    TRACK       = t;
    IMG_MOUNTED = 1'b1;
    @(negedge CLK_14M);
    IMG_MOUNTED = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    bit         ok;
    RESET        = 1'b1;
    IMG_MOUNTED  = 1'b0;
    IMG_READONLY = 1'b0;
    TRACK        = '0;
    TRACK_ADDR   = '0;
    TRACK_DI     = '0;
    TRACK_WE     = 1'b0;

    repeat (3) @(negedge CLK_14M);
    check("rst_busy", int'(TRACK_BUSY), 1);
    check("rst_ready", int'(DISK_READY), 0);
    check("rst_sd_rd", int'(SD_RD), 0);
    check("rst_sd_wr", int'(SD_WR), 0);
    check("rst_lba", int'(SD_LBA), 0);
    check("rst_track_do", int'(TRACK_DO), 0);
    check("rst_buff_din", int'(SD_BUFF_DIN), 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK_14M);
    check("no_load_unmounted", int'(TRACK_BUSY), 1);

    // Scenario 1: mount and load track 0
    push_reqs(0, 0, 13);
    blocks_done = 0;
    pulse_mount(6'd0);
    check("s1_disk_ready", int'(DISK_READY), 1);
    wait_not_busy("s1_busy_falls");
    check("s1_blocks_at_busy_fall", blocks_done, 13);
    load_model(0);
    read_do(13'h19FF, v);
    check("s1_do_19ff", int'(v), int'(data(12, 511)));
    read_do(13'h0000, v);
    check("s1_do_0000", int'(v), int'(data(0, 0)));

    // Scenario 2: dirty write-back then load track 1
    drive_write(13'h0200, 8'hA5);
    model_buf[13'h0200] = 8'hA5;
    read_do(13'h0200, v);
    check("s2_do_after_write", int'(v), 8'hA5);
    push_reqs(1, 0, 13);
    push_reqs(0, 13, 13);
    blocks_done = 0;
    wr_blocks = 0;
    TRACK = 6'd1;
    wait_not_busy("s2_busy_falls");
    check("s2_blocks", blocks_done, 26);
    check("s2_wr_blocks", wr_blocks, 13);
    check("s2_wb_blk1_idx0", int'(wb_b1_0), 8'hA5);
    load_model(1);
    read_do(13'h0000, v);
    check("s2_do_0000", int'(v), int'(data(13, 0)));

    // Scenario 3: read-only image, no write-back
    IMG_READONLY = 1'b1;
    push_reqs(0, 0, 13);
    pulse_mount(6'd0);
    wait_not_busy("s3_remount_busy_falls");
    load_model(0);
    drive_write(13'h0200, 8'hA5);
    push_reqs(0, 13, 13);
    wr_blocks = 0;
    TRACK = 6'd1;
    wait_not_busy("s3_busy_falls");
    check("s3_no_wr_blocks", wr_blocks, 0);
    load_model(1);
    read_do(13'h0200, v);
    check("s3_do_0200", int'(v), int'(data(14, 0)));
    IMG_READONLY = 1'b0;

    // Scenario 4: out-of-range track clamps to MAX_TRACK
    push_reqs(0, 442, 13);
    TRACK = 6'd40;
    wait_not_busy("s4_busy_falls");
    repeat (20) @(negedge CLK_14M);
    check("s4_busy_stays_low", int'(TRACK_BUSY), 0);
    load_model(34);
    read_do(13'h19FF, v);
    check("s4_do_19ff", int'(v), int'(data(454, 511)));

    // Scenario 5: track change mid-load finishes then reloads
    push_reqs(0, 0, 13);
    push_reqs(0, 65, 13);
    blocks_done = 0;
    TRACK = 6'd0;
    ok = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK_14M);
      if (SD_ACK && SD_LBA == 32'd6) begin
        ok = 1;
        break;
      end
    end
    check("s5_reached_block6", int'(ok), 1);
    TRACK = 6'd5;
    wait_not_busy("s5_busy_falls");
    check("s5_blocks", blocks_done, 26);
    load_model(5);
    read_do(13'h0000, v);
    check("s5_do_0000", int'(v), int'(data(65, 0)));
    read_do(13'h19FF, v);
    check("s5_do_19ff", int'(v), int'(data(77, 511)));

    // Scenario 6: reset during a read transfer
    abort_idx = 100;
    abort_lba = 81;
    push_reqs(0, 78, 4);
    TRACK = 6'd6;
    ok = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK_14M);
      if (host_stalled) begin
        ok = 1;
        break;
      end
    end
    check("s6_host_in_block3", int'(ok), 1);
    RESET = 1'b1;
    @(negedge CLK_14M);
    check("s6_sd_rd", int'(SD_RD), 0);
    check("s6_sd_wr", int'(SD_WR), 0);
    check("s6_busy", int'(TRACK_BUSY), 1);
    check("s6_ready", int'(DISK_READY), 0);
    RESET = 1'b0;
    abort_lba = -1;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK_14M);
      if (host_junk_done) begin
        ok = 1;
        break;
      end
    end
    check("s6_junk_issued", int'(ok), 1);
    repeat (40) @(negedge CLK_14M);
    check("s6_busy_after", int'(TRACK_BUSY), 1);
    check("s6_ready_after", int'(DISK_READY), 0);
    for (int a = 0; a < 8; a++) begin
      read_do(13'(a), v);
      check("s6_ram_untouched", int'(v), int'(data(78, a)));
    end
    read_do(13'd100, v);
    check("s6_ram_untouched_100", int'(v), int'(data(78, 100)));

    check("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
